// File: rtl/del_node_conn_stream_if.sv
// rtl/del_node_conn_stream_if.sv - gene stream handshake bundle for del_node_conn_stream
interface del_node_conn_stream_if #(
    parameter int GENE_SZ = 64
) ();
    logic               in_valid;
    logic               in_ready;
    logic [GENE_SZ-1:0] in_gene;
    logic               in_is_conn;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [GENE_SZ-1:0] out_gene;
    logic               out_keep;
    logic               out_last;

    modport master (
        output in_valid, in_gene, in_is_conn, in_last, out_ready,
        input  in_ready, out_valid, out_gene, out_keep, out_last
    );

    modport slave (
        input  in_valid, in_gene, in_is_conn, in_last, out_ready,
        output in_ready, out_valid, out_gene, out_keep, out_last
    );
endinterface

// File: rtl/del_node_conn_stream.sv
// rtl/del_node_conn_stream.sv - streaming NEAT node/connection deletion stage
// Optional per-genome deletion statistics enabled by DEL_NODE_CONN_STATS_EN.
module del_node_conn_stream #(
    parameter int GENE_SZ        = 64,
    parameter int ATTR_SZ        = 8,
    parameter int DEL_LIST_DEPTH = 8,
    parameter int CNT_W          = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    del_node_conn_stream_if.slave s,
    input  logic [ATTR_SZ-1:0]    node_del_prob,
    input  logic [ATTR_SZ-1:0]    conn_del_prob,
    input  logic [ATTR_SZ-1:0]    random,
    output logic                  phase_err,
    output logic [CNT_W-1:0]      stat_node_del,
    output logic [CNT_W-1:0]      stat_conn_del,
    output logic                  stat_valid
);
    localparam int CW = $clog2(DEL_LIST_DEPTH + 1);
    localparam int IW = (DEL_LIST_DEPTH > 1) ? $clog2(DEL_LIST_DEPTH) : 1;

    typedef enum logic {S_NODE, S_CONN} state_t;

    state_t                    state;
    logic [ATTR_SZ-1:0]        list_id [DEL_LIST_DEPTH];
    logic [DEL_LIST_DEPTH-1:0] list_vld;
    logic [CW-1:0]             list_cnt;

    logic               accept, list_hit, list_full;
    logic               node_del, conn_del, gene_del, misphased;
    logic [1:0]         node_type;
    logic [ATTR_SZ-1:0] node_id, dest_id;

    assign node_type = s.in_gene[7*ATTR_SZ-2 -: 2];
    assign node_id   = s.in_gene[6*ATTR_SZ-1 -: ATTR_SZ];
    assign dest_id   = s.in_gene[5*ATTR_SZ-1 -: ATTR_SZ];

    assign s.in_ready = !s.out_valid || s.out_ready;
    assign accept     = s.in_valid && s.in_ready;
    assign list_full  = (list_cnt >= CW'(DEL_LIST_DEPTH));
    assign misphased  = !s.in_is_conn && (state == S_CONN);

    // Only valid-tagged entries compare, so cleared slots holding ID 0 never match
    always_comb begin
        list_hit = 1'b0;
        for (int i = 0; i < DEL_LIST_DEPTH; i++) begin
            if (list_vld[i] && (list_id[i] == node_id || list_id[i] == dest_id)) begin
                list_hit = 1'b1;
            end
        end
    end

    assign node_del = !s.in_is_conn && (state == S_NODE) && (random > node_del_prob)
                      && (node_type == 2'b00) && !list_full;
    assign conn_del = s.in_is_conn && (list_hit || (random > conn_del_prob));
    assign gene_del = node_del || conn_del;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_NODE;
            list_cnt    <= '0;
            list_vld    <= '0;
            for (int i = 0; i < DEL_LIST_DEPTH; i++) begin
                list_id[i] <= '0;
            end
            s.out_valid <= 1'b0;
            s.out_gene  <= '0;
            s.out_keep  <= 1'b0;
            s.out_last  <= 1'b0;
            phase_err   <= 1'b0;
        end else begin
            if (accept) begin
                s.out_valid <= 1'b1;
                s.out_gene  <= gene_del ? '0 : s.in_gene;
                s.out_keep  <= !gene_del;
                s.out_last  <= s.in_last;
                if (misphased) begin
                    phase_err <= 1'b1;
                end
                // The closing beat is judged against the list, then the list is dropped
                if (s.in_last) begin
                    state    <= S_NODE;
                    list_cnt <= '0;
                    list_vld <= '0;
                end else begin
                    if (s.in_is_conn) begin
                        state <= S_CONN;
                    end
                    if (node_del) begin
                        list_id[list_cnt[IW-1:0]]  <= node_id;
                        list_vld[list_cnt[IW-1:0]] <= 1'b1;
                        list_cnt                   <= list_cnt + 1'b1;
                    end
                end
            end else if (s.out_ready) begin
                s.out_valid <= 1'b0;
            end
        end
    end

`ifdef DEL_NODE_CONN_STATS_EN
    logic [CNT_W-1:0] node_cnt, conn_cnt, node_nxt, conn_nxt;

    always_comb begin
        node_nxt = (node_del && node_cnt != '1) ? node_cnt + 1'b1 : node_cnt;
        conn_nxt = (conn_del && conn_cnt != '1) ? conn_cnt + 1'b1 : conn_cnt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            node_cnt      <= '0;
            conn_cnt      <= '0;
            stat_node_del <= '0;
            stat_conn_del <= '0;
            stat_valid    <= 1'b0;
        end else begin
            stat_valid <= 1'b0;
            if (accept) begin
                if (s.in_last) begin
                    stat_node_del <= node_nxt;
                    stat_conn_del <= conn_nxt;
                    stat_valid    <= 1'b1;
                    node_cnt      <= '0;
                    conn_cnt      <= '0;
                end else begin
                    node_cnt <= node_nxt;
                    conn_cnt <= conn_nxt;
                end
            end
        end
    end
`else
    assign stat_node_del = '0;
    assign stat_conn_del = '0;
    assign stat_valid    = 1'b0;
`endif
endmodule

// File: tb/tb_del_node_conn_stream.sv
// tb/tb_del_node_conn_stream.sv - randomized and directed bench for del_node_conn_stream
module tb_del_node_conn_stream;
    localparam int DEPTH = 4;

    typedef struct packed {logic [63:0] gene; logic keep; logic last;} beat_t;
    typedef struct packed {logic [7:0] n; logic [7:0] c;} stat_t;

    logic       clk, rst;
    logic [7:0] np, cp, rnd_in;
    logic       phase_err, stat_valid;
    logic [7:0] stat_nd, stat_cd;

    del_node_conn_stream_if #(.GENE_SZ(64)) s ();

    del_node_conn_stream #(.GENE_SZ(64), .ATTR_SZ(8), .DEL_LIST_DEPTH(DEPTH), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .s(s),
        .node_del_prob(np), .conn_del_prob(cp), .random(rnd_in),
        .phase_err(phase_err), .stat_node_del(stat_nd), .stat_conn_del(stat_cd),
        .stat_valid(stat_valid)
    );

    int    n_checks = 0;
    int    n_fail   = 0;
    int    bp_mode  = 0;
    beat_t exp_q[$], got_q[$];
    stat_t exp_st[$], got_st[$];
    int    m_list[$];
    bit    m_conn_phase = 0, m_perr = 0;
    int    m_nd = 0, m_cd = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output-ready driver: 0 = always ready, 1 = random stalls, 2 = held low by a test
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode == 1) s.out_ready = ($urandom % 4) != 0;
            else if (bp_mode == 0) s.out_ready = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (s.out_valid && s.out_ready) got_q.push_back('{s.out_gene, s.out_keep, s.out_last});
            if (stat_valid) got_st.push_back('{stat_nd, stat_cd});
        end
    end

    function automatic logic [63:0] mk(input logic [1:0] t, input logic [7:0] a, input logic [7:0] b);
        logic [63:0] g;
        g = {$urandom, $urandom};
        g[54:53] = t;
        g[47:40] = a;
        g[39:32] = b;
        return g;
    endfunction

    function automatic logic [7:0] sat8(input int x);
        return (x > 255) ? 8'hFF : x[7:0];
    endfunction

    // Reference: list of deleted IDs per genome, deletion rules applied beat by beat
    task automatic model_beat(input logic [63:0] g, input bit is_conn, input bit last, input logic [7:0] r);
        bit del = 0;
        int id  = g[47:40];
        int dst = g[39:32];
        if (!is_conn) begin
            if (m_conn_phase) m_perr = 1;
            else if (r > np && g[54:53] == 2'b00 && m_list.size() < DEPTH) begin
                del = 1;
                m_list.push_back(id);
                m_nd++;
            end
        end else begin
            foreach (m_list[i]) if (m_list[i] == id || m_list[i] == dst) del = 1;
            if (r > cp) del = 1;
            if (del) m_cd++;
        end
        exp_q.push_back('{del ? 64'd0 : g, !del, last});
        if (last) begin
            exp_st.push_back('{sat8(m_nd), sat8(m_cd)});
            m_list.delete();
            m_conn_phase = 0;
            m_nd = 0;
            m_cd = 0;
        end else if (is_conn) m_conn_phase = 1;
    endtask

    task automatic model_reset();
        m_list.delete();
        m_conn_phase = 0;
        m_perr = 0;
        m_nd = 0;
        m_cd = 0;
    endtask

    task automatic clear_queues();
        exp_q.delete(); got_q.delete(); exp_st.delete(); got_st.delete();
    endtask

    task automatic drive(input logic [63:0] g, input bit is_conn, input bit last, input logic [7:0] r);
        model_beat(g, is_conn, last, r);
        s.in_valid = 1'b1; s.in_gene = g; s.in_is_conn = is_conn; s.in_last = last; rnd_in = r;
    endtask

    task automatic wait_accept();
        int n = 0;
        do begin @(negedge clk); n++; end while (!s.in_ready && n < 200);
        if (!s.in_ready) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout in_ready stuck at %b, required 1", s.in_ready);
        end
        @(posedge clk);
        #1;
        s.in_valid = 1'b0;
    endtask

    task automatic send(input logic [63:0] g, input bit is_conn, input bit last, input logic [7:0] r);
        drive(g, is_conn, last, r);
        wait_accept();
    endtask

    task automatic drain();
        int n = 0;
        while (got_q.size() < exp_q.size() && n < 2000) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL beat_count got %0d beats, required %0d", got_q.size(), exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; s.in_valid = 0; s.in_gene = '0; s.in_is_conn = 0; s.in_last = 0;
        s.out_ready = 1'b1; np = 8'hFF; cp = 8'hFF; rnd_in = 0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({s.out_valid, s.out_gene, s.out_keep, s.out_last, phase_err, stat_nd, stat_cd, stat_valid} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got valid=%b gene=%h keep=%b last=%b perr=%b stats=%h/%h/%b, required all 0",
                     s.out_valid, s.out_gene, s.out_keep, s.out_last, phase_err, stat_nd, stat_cd, stat_valid);
        end
        n_checks++;
        if (s.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b, required 1", s.in_ready); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        clear_queues();
    endtask

    task automatic test_node_delete();
        clear_queues();
        np = 8'h40; cp = 8'hFF;
        send(mk(2'b00, 8'd5, 8'd0), 0, 0, 8'h80);
        n_checks++;
        if ({s.out_valid, s.out_keep, s.out_gene} !== {1'b1, 1'b0, 64'd0}) begin
            n_fail++;
            $display("FAIL node_latency got valid=%b keep=%b gene=%h, required 1 0 0", s.out_valid, s.out_keep, s.out_gene);
        end
        send(mk(2'b00, 8'd6, 8'd0), 0, 0, 8'h80);
        send(mk(2'b00, 8'd7, 8'd0), 0, 0, 8'h80);
        drain();
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i] || got_q[i].keep !== 1'b0 || got_q[i].gene !== 64'd0) begin
                n_fail++;
                $display("FAIL node_delete beat %0d got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_conn_match();
        logic [63:0] g1;
        bit exp_keep[3] = '{0, 1, 0};
        clear_queues();
        cp = 8'hFF;
        g1 = mk(2'b00, 8'd3, 8'd4);
        send(mk(2'b00, 8'd5, 8'd9), 1, 0, 8'($urandom));
        send(g1, 1, 0, 8'($urandom));
        send(mk(2'b00, 8'd2, 8'd7), 1, 1, 8'($urandom));
        drain();
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i] || got_q[i].keep !== exp_keep[i]) begin
                n_fail++;
                $display("FAIL conn_match beat %0d got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (got_q.size() > 1 && got_q[1].gene !== g1) begin
            n_fail++;
            $display("FAIL conn_kept_gene got %h, required %h", got_q[1].gene, g1);
        end
    endtask

    task automatic test_list_full();
        bit exp_keep[8] = '{0, 0, 0, 0, 1, 1, 1, 0};
        clear_queues();
        np = 8'h00; cp = 8'hFF;
        for (int i = 1; i <= 6; i++) send(mk(2'b00, 8'(i), 8'd0), 0, 0, 8'($urandom_range(1, 255)));
        send(mk(2'b00, 8'd5, 8'd6), 1, 0, 8'($urandom));
        send(mk(2'b00, 8'd9, 8'd1), 1, 1, 8'($urandom));
        drain();
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i] || got_q[i].keep !== exp_keep[i]) begin
                n_fail++;
                $display("FAIL list_full beat %0d got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_id_zero();
        bit exp_keep[4] = '{0, 1, 1, 1};
        clear_queues();
        np = 8'h00; cp = 8'hFF;
        send(mk(2'b00, 8'd5, 8'd0), 0, 0, 8'h80);
        np = 8'hFF;
        send(mk(2'b00, 8'd0, 8'd0), 0, 0, 8'($urandom));
        send(mk(2'b00, 8'd0, 8'd0), 1, 1, 8'($urandom));
        send(mk(2'b00, 8'd5, 8'd9), 1, 1, 8'($urandom));
        drain();
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i] || got_q[i].keep !== exp_keep[i]) begin
                n_fail++;
                $display("FAIL id_zero beat %0d got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [65:0] held;
        int n = 0;
        clear_queues();
        np = 8'h00; cp = 8'hFF;
        bp_mode = 2; s.out_ready = 1'b0;
        send(mk(2'b00, 8'd3, 8'd0), 0, 0, 8'h80);
        drive(mk(2'b01, 8'd4, 8'd0), 0, 0, 8'h80);
        @(negedge clk);
        held = {s.out_gene, s.out_keep, s.out_last};
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (s.in_ready !== 1'b0 || {s.out_gene, s.out_keep, s.out_last} !== held || held !== 66'd0) begin
                n_fail++;
                $display("FAIL stall_cycle %0d got in_ready=%b out=%h, required 0 and %h", i, s.in_ready,
                         {s.out_gene, s.out_keep, s.out_last}, 66'd0);
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bp_mode = 0; s.out_ready = 1'b1;
        while (!s.in_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        #1;
        s.in_valid = 1'b0;
        send(mk(2'b00, 8'd3, 8'd8), 1, 0, 8'h00);
        send(mk(2'b10, 8'd11, 8'd0), 0, 1, 8'h80);
        drain();
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL backpressure beat %0d got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (phase_err !== 1'b1 || got_q.size() < 4 || got_q[3].keep !== 1'b1) begin
            n_fail++;
            $display("FAIL phase_err got %b, required 1 with misphased beat kept", phase_err);
        end
    endtask

    task automatic test_stats();
        clear_queues();
        np = 8'h00; cp = 8'h10;
        send(mk(2'b00, 8'd1, 8'd0), 0, 0, 8'h80);
        send(mk(2'b00, 8'd2, 8'd0), 0, 0, 8'h80);
        send(mk(2'b01, 8'd3, 8'd0), 0, 0, 8'h80);
        send(mk(2'b00, 8'd1, 8'd3), 1, 0, 8'h00);
        send(mk(2'b00, 8'd2, 8'd5), 1, 0, 8'h00);
        send(mk(2'b00, 8'd6, 8'd7), 1, 0, 8'h80);
        send(mk(2'b00, 8'd6, 8'd8), 1, 1, 8'h05);
        drain();
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL stats_stream beat %0d got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
`ifdef DEL_NODE_CONN_STATS_EN
        n_checks++;
        if (got_st.size() != 1 || got_st[0] !== stat_t'({8'd2, 8'd3}) || got_st[0] !== exp_st[0]) begin
            n_fail++;
            $display("FAIL stats_pulse got %0d pulses first=%h, required 1 pulse %h",
                     got_st.size(), (got_st.size() > 0) ? got_st[0] : 16'hxxxx, 16'h0203);
        end
`else
        n_checks++;
        if (got_st.size() != 0 || {stat_nd, stat_cd, stat_valid} !== '0) begin
            n_fail++;
            $display("FAIL stats_disabled got %0d pulses nd=%h cd=%h, required none and 0", got_st.size(), stat_nd, stat_cd);
        end
`endif
    endtask

    task automatic test_random();
        clear_queues();
        bp_mode = 1;
        for (int gnm = 0; gnm < 40; gnm++) begin
            int nn = $urandom_range(0, 6);
            int nc = $urandom_range(0, 6);
            bit misplace;
            int mode = $urandom_range(0, 3);
            if (nn + nc == 0) nn = 1;
            misplace = ($urandom % 6 == 0) && nc > 0;
            np = (mode == 0) ? 8'hFF : (mode == 1) ? 8'h00 : 8'($urandom);
            cp = (mode == 1) ? 8'hFF : 8'($urandom_range(128, 255));
            for (int i = 0; i < nn + nc; i++) begin
                bit       is_conn = (i >= nn);
                bit       last    = (i == nn + nc - 1);
                logic [1:0] t     = ($urandom % 3 == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                if (misplace && last) is_conn = 0;
                send(mk(t, 8'($urandom_range(0, 9)), 8'($urandom_range(0, 9))), is_conn, last, 8'($urandom));
            end
        end
        drain();
        bp_mode = 0;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL random beat %0d got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (phase_err !== m_perr) begin n_fail++; $display("FAIL random_phase_err got %b, required %b", phase_err, m_perr); end
`ifdef DEL_NODE_CONN_STATS_EN
        n_checks++;
        if (got_st.size() != exp_st.size()) begin
            n_fail++;
            $display("FAIL random_stat_count got %0d, required %0d", got_st.size(), exp_st.size());
        end
        for (int i = 0; i < exp_st.size() && i < got_st.size(); i++) begin
            n_checks++;
            if (got_st[i] !== exp_st[i]) begin
                n_fail++;
                $display("FAIL random_stat %0d got %h, required %h", i, got_st[i], exp_st[i]);
            end
        end
`else
        n_checks++;
        if (got_st.size() != 0) begin n_fail++; $display("FAIL random_stats_disabled got %0d pulses, required 0", got_st.size()); end
`endif
    endtask

    task automatic test_async_reset();
        clear_queues();
        np = 8'h00; cp = 8'hFF;
        bp_mode = 2; s.out_ready = 1'b0;
        send(mk(2'b00, 8'd5, 8'd0), 0, 0, 8'h80);
        s.in_valid = 1'b1; s.in_gene = mk(2'b00, 8'd6, 8'd0); s.in_is_conn = 0; s.in_last = 0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({s.out_valid, s.out_gene, s.out_keep, phase_err} !== '0) begin
            n_fail++;
            $display("FAIL async_reset got valid=%b gene=%h keep=%b perr=%b, required all 0", s.out_valid, s.out_gene, s.out_keep, phase_err);
        end
        s.in_valid = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bp_mode = 0; s.out_ready = 1'b1;
        clear_queues();
        send(mk(2'b00, 8'd5, 8'd9), 1, 1, 8'($urandom));
        drain();
        n_checks++;
        if (got_q.size() != 1 || got_q[0] !== exp_q[0] || got_q[0].keep !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_list got %0d beats first=%h, required kept %h", got_q.size(),
                     (got_q.size() > 0) ? got_q[0] : 66'd0, exp_q[0]);
        end
    endtask

    initial begin
        test_reset();
        test_node_delete();
        test_conn_match();
        test_list_full();
        test_id_zero();
        test_backpressure();
        test_stats();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/del_node_conn_stream.md
Name: del_node_conn_stream

Overview:
- Streaming genome-deletion mutation stage for the NEAT hardware pipeline. It takes one genome per packet: node genes first, then connection genes.
- Hidden node genes are deleted probabilistically. Their IDs are recorded in a parametrised delete list.
- Connection genes are deleted when they touch a listed node, or probabilistically.
- Successor to the fixed-depth, state-input deletion stage. Adds a valid/ready handshake, an internal phase FSM, genome framing, valid-tagged list entries and per-genome list clearing.

Parameters:
- GENE_SZ, 64, gene word width.
- ATTR_SZ, 8, attribute field width (node ID, probabilities, random).
- DEL_LIST_DEPTH, 8, maximum node deletions per genome (1..32).
- CNT_W, 8, width of statistics counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid & in_ready.
- in_gene  in  GENE_SZ  gene word.
- in_is_conn  in  1  1 = connection gene, 0 = node gene.
- in_last  in  1  last gene of the genome.
- node_del_prob  in  ATTR_SZ  node deletion threshold.
- conn_del_prob  in  ATTR_SZ  connection deletion threshold.
- random  in  ATTR_SZ  random sample, used on the accepting cycle.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream ready.
- out_gene  out  GENE_SZ  gene, or zero when deleted.
- out_keep  out  1  1 = gene kept, 0 = gene deleted.
- out_last  out  1  copy of in_last for this beat.
- phase_err  out  1  sticky: node gene arrived during connection phase.
- stat_node_del  out  CNT_W  nodes deleted in last completed genome.
- stat_conn_del  out  CNT_W  connections deleted in last completed genome.
- stat_valid  out  1  1-cycle pulse when stats update.

Behaviour:
- Field map:
  - node_type = in_gene[7*ATTR_SZ-2 : 7*ATTR_SZ-3]
  - node_id = src = in_gene[6*ATTR_SZ-1 : 5*ATTR_SZ]
  - dest = in_gene[5*ATTR_SZ-1 : 4*ATTR_SZ]
- Reset values: out_valid=0, out_gene=0, out_keep=0, out_last=0, phase_err=0, stats=0, stat_valid=0. Also list count=0, all list valid bits=0, FSM=S_NODE.
- Handshake:
  - Single output register; in_ready = !out_valid | out_ready. Full throughput, latency 1 cycle.
  - Every accepted beat produces exactly one output beat, deleted or not; ordering is preserved.
  - Output holds stable while out_valid & !out_ready.
- FSM states: S_NODE and S_CONN.
  - S_NODE -> S_CONN on an accepted beat with in_is_conn=1 and in_last=0.
  - Any accepted in_last beat -> S_NODE. On that beat the list is cleared (count=0, valid bits=0) after the beat is evaluated.
- Node gene (in_is_conn=0) in S_NODE is deleted iff all of:
  - random > node_del_prob (unsigned, strict);
  - node_type == 2'b00 (hidden);
  - list count < DEL_LIST_DEPTH.
- On node deletion, node_id is written to entry[count], its valid bit is set, and count increments.
- When the list is full, hidden nodes pass kept. Input and output node types always pass kept.
- Connection gene is deleted iff any of:
  - src or dest equals a valid list entry (only valid-tagged entries compare, so ID 0 never falsely matches);
  - random > conn_del_prob.
- Matching uses list contents as of the start of the cycle.
- A node gene accepted in S_CONN sets phase_err (cleared only by rst), is passed kept, and does not modify the list.
- A deleted beat outputs out_gene=0, out_keep=0, out_valid=1.
- Genome of a single beat (in_last on first beat): the beat is processed, then the list is cleared.
- Reset mid-genome: everything returns to reset values immediately; the in-flight output beat is lost.
- Probability 0xFF threshold: never deletes, since random > 0xFF is impossible.

Optional Feature:
- Macro DEL_NODE_CONN_STATS_EN.
- When defined:
  - Internal counters count deleted node and connection beats of the current genome, saturating at 2^CNT_W-1.
  - On the accepted in_last beat, final counts (including that beat) load into stat_node_del/stat_conn_del. stat_valid pulses the following cycle, and the internal counters clear.
- When undefined: stat_node_del, stat_conn_del and stat_valid are tied to 0 and no counter logic exists.

Test Plan:
1. Reset, then out_ready=1 and 3 hidden node genes with IDs 5, 6, 7, random=0x80, node_del_prob=0x40 -> 3 output beats with out_keep=0 and out_gene=0, one cycle after each input.
2. Following conn genes src5->dest9, src3->dest4, src2->dest7 with conn_del_prob=0xFF -> out_keep sequence 0, 1, 0; the kept beat has out_gene equal to the input word.
3. DEL_LIST_DEPTH=2, 4 hidden nodes with IDs 1..4, all eligible -> keep pattern 0, 0, 1, 1; a conn 3->4 then passes kept.
4. Node ID 0 never deleted (node_del_prob=0xFF) and conn 0->0 with conn_del_prob=0xFF -> kept (no false match on empty list). Genome ends with in_last; next genome's conn 5->9 is kept because the list was cleared.
5. out_ready low 4 cycles during stream -> in_ready low, out_gene/out_keep stable, no beat lost or duplicated. Also: node gene after a conn gene -> phase_err=1, beat kept.
6. With DEL_NODE_CONN_STATS_EN, genome with 2 deleted nodes and 3 deleted conns -> stat_node_del=2, stat_conn_del=3, one-cycle stat_valid pulse. Without the macro, all three stat outputs read 0.
